// File: rtl/vm2413_pkg.sv
// Shared VM2413 types used by the feedback store controller.
package vm2413;

  typedef logic signed [9:0] SIGNED_LI_TYPE;

  localparam int unsigned FB_NCH = 9;

  typedef struct packed {
    logic [3:0]    ch;
    SIGNED_LI_TYPE data;
  } fb_wr_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Write queue for the feedback store: shift FIFO (index 0 = head) with a
// combinational channel-match port used for read bypass.
module fb_wr_fifo
  import vm2413::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          push,
  input  fb_wr_t        push_entry,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output fb_wr_t        head,
  input  logic [3:0]    match_ch,
  output logic          match_hit,
  output SIGNED_LI_TYPE match_data
);

  localparam int unsigned CW = $clog2(Depth + 1);

  fb_wr_t         entries_q [Depth];
  fb_wr_t         entries_d [Depth];
  logic [CW-1:0]  count_q, count_d;

  assign full  = (count_q == CW'(Depth));
  assign empty = (count_q == '0);
  assign head  = entries_q[0];

  always_comb begin
    entries_d = entries_q;
    count_d   = count_q;
    if (pop && !empty) begin
      for (int i = 0; i < int'(Depth) - 1; i++) begin
        entries_d[i] = entries_q[i + 1];
      end
      count_d = count_d - 1'b1;
    end
    if (push && (count_d != CW'(Depth))) begin
      for (int i = 0; i < int'(Depth); i++) begin
        if (count_d == CW'(i)) entries_d[i] = push_entry;
      end
      count_d = count_d + 1'b1;
    end
    if (flush) count_d = '0;
  end

  // Later (younger) entries override earlier ones, so the newest match wins.
  always_comb begin
    match_hit  = 1'b0;
    match_data = '0;
    for (int i = 0; i < int'(Depth); i++) begin
      if ((CW'(i) < count_q) && (entries_q[i].ch == match_ch)) begin
        match_hit  = 1'b1;
        match_data = entries_q[i].data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      for (int i = 0; i < int'(Depth); i++) entries_q[i] <= '0;
    end else begin
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

endmodule

// File: rtl/feedback_mem_ctrl.sv
// Per-channel feedback store controller: zero-fill sweep, read/write
// arbitration with a bypassing write queue and a write-starvation limit.
module feedback_mem_ctrl
  import vm2413::*;
#(
  parameter int unsigned NCH        = FB_NCH,
  parameter int unsigned DW         = $bits(SIGNED_LI_TYPE),
  parameter int unsigned WQ_DEPTH   = 2,
  parameter int unsigned STARVE_MAX = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  output logic          busy,
  input  logic          rd_req,
  input  logic [3:0]    rd_ch,
  output logic          rd_ready,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  input  logic          wr_req,
  input  logic [3:0]    wr_ch,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [3:0]    mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e        state_q, state_d;
  logic [3:0]    ptr_q, ptr_d;
  logic [SW-1:0] starve_q, starve_d;

  logic          fifo_full, fifo_empty, fifo_push, fifo_flush, fifo_hit;
  fb_wr_t        fifo_head, push_entry;
  SIGNED_LI_TYPE fifo_hit_data;

  logic          rd_grant, wr_grant, rd_in_range, wr_in_range, run;
  logic          p1_valid_q, p1_hit_q, rd_valid_q;
  logic [DW-1:0] p1_data_q, rd_data_q;

  assign run         = (state_q == StRun);
  assign busy        = (state_q == StInit);
  assign rd_in_range = ({1'b0, rd_ch} < 5'(NCH));
  assign wr_in_range = ({1'b0, wr_ch} < 5'(NCH));
  assign rd_ready    = run && !(fifo_full && (starve_q >= SW'(STARVE_MAX)));
  assign wr_ack      = run && !fifo_full;
  assign push_entry  = '{ch: wr_ch, data: SIGNED_LI_TYPE'(wr_data)};
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;

  fb_wr_fifo #(
    .Depth(WQ_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_entry(push_entry),
    .pop       (wr_grant),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head),
    .match_ch  (rd_ch),
    .match_hit (fifo_hit),
    .match_data(fifo_hit_data)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    starve_d   = starve_q;
    rd_grant   = 1'b0;
    wr_grant   = 1'b0;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    unique case (state_q)
      StInit: begin
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = ptr_q;
        ptr_d    = ptr_q + 4'd1;
        if (ptr_q == 4'(NCH - 1)) begin
          state_d = StRun;
          ptr_d   = '0;
        end
        if (clr) begin
          state_d = StInit;
          ptr_d   = '0;
        end
      end
      StRun: begin
        if (clr) begin
          state_d    = StInit;
          ptr_d      = '0;
          fifo_flush = 1'b1;
          starve_d   = '0;
        end else begin
          rd_grant  = rd_req && rd_ready;
          wr_grant  = !rd_grant && !fifo_empty;
          // Out-of-range writes are acknowledged but never queued.
          fifo_push = wr_req && wr_ack && wr_in_range;
          if (rd_grant && rd_in_range) begin
            mem_en   = 1'b1;
            mem_addr = rd_ch;
          end else if (wr_grant) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = fifo_head.ch;
            mem_wdata = DW'(fifo_head.data);
          end
          if (wr_grant) begin
            starve_d = '0;
          end else if (!fifo_empty && (starve_q < SW'(STARVE_MAX))) begin
            starve_d = starve_q + 1'b1;
          end
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StInit;
      ptr_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      starve_q <= starve_d;
    end
  end

  // Stage 1 captures bypass data at accept; stage 2 picks it or the memory word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1_valid_q <= 1'b0;
      p1_hit_q   <= 1'b0;
      p1_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      p1_valid_q <= rd_grant;
      if (rd_grant) begin
        p1_hit_q  <= fifo_hit || !rd_in_range;
        p1_data_q <= fifo_hit ? DW'(fifo_hit_data) : '0;
      end
      rd_valid_q <= p1_valid_q && !clr;
      if (p1_valid_q && !clr) begin
        rd_data_q <= p1_hit_q ? p1_data_q : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_feedback_mem_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic, checked against
// a "reads return the newest write acknowledged before accept" value model.
module tb_feedback_mem_ctrl;

  localparam int NCH = 9;

  logic       clk, reset_n, clr, busy;
  logic       rd_req, rd_ready, rd_valid, wr_req, wr_ack;
  logic [3:0] rd_ch, wr_ch, mem_addr;
  logic [9:0] rd_data, wr_data, mem_wdata, mem_rdata;
  logic       mem_en, mem_we;

  feedback_mem_ctrl dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (clr),
    .busy     (busy),
    .rd_req   (rd_req),
    .rd_ch    (rd_ch),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .wr_req   (wr_req),
    .wr_ch    (wr_ch),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory with registered read data.
  logic [9:0] ram [16];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  typedef struct {
    int         due;
    logic [9:0] val;
  } rd_exp_t;

  int         n_chk = 0, n_err = 0, cyc = 0, sweep_left = 0;
  logic [9:0] shadow [NCH];
  rd_exp_t    pend [$];
  logic       last_busy, last_rd_ready, last_wr_ack, last_rd_valid;
  logic [9:0] last_rd_data;
  logic [15:0] last_op;
  int         found;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic monitor();
    logic exp_busy, exp_v;
    cyc++;
    exp_busy = (sweep_left > 0);
    check_eq("busy", busy, exp_busy);
    if (mem_en) check_eq("mem_addr_range", mem_addr < 4'd9, 1);
    else        check_eq("mem_idle", {mem_we, mem_addr}, 0);
    if (exp_busy) begin
      check_eq("sweep_op", {mem_en, mem_we, mem_addr, mem_wdata},
               {1'b1, 1'b1, 4'(9 - sweep_left), 10'd0});
      check_eq("init_handshake", {rd_ready, wr_ack}, 0);
    end
    exp_v = (pend.size() > 0) && (pend[0].due == cyc);
    check_eq("rd_valid", rd_valid, exp_v);
    if (exp_v) begin
      if (rd_valid) check_eq("rd_data", rd_data, pend[0].val);
      void'(pend.pop_front());
    end
    last_busy     = busy;
    last_rd_ready = rd_ready;
    last_wr_ack   = wr_ack;
    last_rd_valid = rd_valid;
    last_rd_data  = rd_data;
    last_op       = {mem_en, mem_we, mem_addr, mem_wdata};
    if (clr) begin
      sweep_left = 9;
      pend.delete();
      for (int i = 0; i < NCH; i++) shadow[i] = '0;
    end else if (exp_busy) begin
      sweep_left--;
    end else begin
      if (rd_req && rd_ready)
        pend.push_back('{due: cyc + 2, val: (rd_ch < 4'(NCH)) ? shadow[rd_ch] : 10'd0});
      if (wr_req && wr_ack && (wr_ch < 4'(NCH))) shadow[wr_ch] = wr_data;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rq, input logic [3:0] rc, input logic wq,
                       input logic [3:0] wc, input logic [9:0] wd);
    rd_req  = rq;
    rd_ch   = rc;
    wr_req  = wq;
    wr_ch   = wc;
    wr_data = wd;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    clr     = 1'b0;
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < NCH; i++) shadow[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 1);
    check_eq("rst_rd_valid", rd_valid, 0);
    check_eq("rst_rd_data", rd_data, 0);
    check_eq("rst_rd_ready", rd_ready, 0);
    check_eq("rst_wr_ack", wr_ack, 0);
    reset_n    = 1'b1;
    sweep_left = 9;
    repeat (9) step();
    check_eq("post_sweep_busy", busy, 0);
    check_eq("post_sweep_rd_ready", rd_ready, 1);
    check_eq("post_sweep_wr_ack", wr_ack, 1);

    // Plain write then read back.
    drive(0, 0, 1, 3, 10'h155); step();
    drive(0, 0, 0, 0, 0);       step();
    check_eq("wr3_mem_op", last_op, {1'b1, 1'b1, 4'd3, 10'h155});
    drive(1, 3, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0); step(); step();
    check_eq("rd3_valid", last_rd_valid, 1);
    check_eq("rd3_data", last_rd_data, 10'h155);

    // Starvation: continuous reads, two writes fill the queue.
    drive(1, 0, 1, 5, 10'h011); step();
    drive(1, 0, 1, 5, 10'h3FF); step();
    drive(1, 0, 0, 0, 0);
    found = -1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 1) check_eq("full_wr_ack", last_wr_ack, 0);
      if (!last_rd_ready) begin
        found = i;
        break;
      end
    end
    check_eq("starve_cycle", found, 2);
    check_eq("starve_mem_op", last_op, {1'b1, 1'b1, 4'd5, 10'h011});
    step();
    check_eq("reads_resume", last_rd_ready, 1);
    drive(0, 0, 0, 0, 0);
    repeat (6) step();
    check_eq("ram5_final", ram[5], 10'h3FF);

    // Bypass: newest queued write to ch2 wins over memory.
    drive(1, 0, 1, 2, 10'h2AA); step();
    drive(1, 0, 1, 2, 10'h001); step();
    drive(1, 2, 0, 0, 0);       step();
    drive(0, 0, 0, 0, 0);       step(); step();
    check_eq("bypass_valid", last_rd_valid, 1);
    check_eq("bypass_data", last_rd_data, 10'h001);
    repeat (6) step();

    // Soft clear with queued writes and a read in flight.
    drive(1, 2, 1, 5, 10'h0AB); step();
    drive(1, 2, 1, 5, 10'h0CD); step();
    drive(1, 2, 0, 0, 0);       step();
    drive(0, 0, 0, 0, 0);
    clr = 1'b1; step();
    clr = 1'b0; step();
    check_eq("clr_drop_valid", last_rd_valid, 0);
    check_eq("clr_busy", last_busy, 1);
    repeat (10) step();
    check_eq("clr_ram5", ram[5], 0);
    drive(1, 5, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0); step(); step();
    check_eq("clr_rd5_valid", last_rd_valid, 1);
    check_eq("clr_rd5_data", last_rd_data, 0);

    // Out-of-range channel.
    drive(0, 0, 1, 12, 10'h123); step();
    check_eq("oor_wr_ack", last_wr_ack, 1);
    drive(0, 0, 1, 1, 10'h0F0);  step();
    drive(1, 1, 0, 0, 0);        step();
    drive(1, 12, 0, 0, 0);       step();
    drive(0, 0, 0, 0, 0);        step(); step();
    check_eq("oor_rd_valid", last_rd_valid, 1);
    check_eq("oor_rd_data", last_rd_data, 0);
    repeat (4) step();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 11)),
            ($urandom_range(0, 2) != 0), 4'($urandom_range(0, 11)), 10'($urandom));
      clr = ($urandom_range(0, 299) == 0);
      step();
    end
    clr = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (14) step();
    for (int ch = 0; ch < NCH; ch++) check_eq("final_ram", ram[ch], shadow[ch]);
    check_eq("reads_outstanding", pend.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
